// File: rtl/mem_wb.sv
// MEM/WB pipeline register plus the state committed at write-back:
// the LL/SC link bit and the HI/LO pair.
module mem_wb (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic [5:0]  mem_cnt,
  input  logic [63:0] mem_hilo_tempt,
  input  logic [63:0] mem_minuend,
  input  logic        mem_LLbit_we,
  input  logic        mem_LLbit_value,
  input  logic        mem_cp0_reg_we,
  input  logic [4:0]  mem_cp0_reg_write_addr,
  input  logic [31:0] mem_cp0_reg_data,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic [5:0]  wb_cnt,
  output logic [63:0] wb_hilo_tempt,
  output logic [63:0] wb_minuend,
  output logic        wb_LLbit_we,
  output logic        wb_LLbit_value,
  output logic        wb_cp0_reg_we,
  output logic [4:0]  wb_cp0_reg_write_addr,
  output logic [31:0] wb_cp0_reg_data,
  output logic        LLbit_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic bubble;
  logic load;
  logic commit;

  assign bubble = stall[4] & ~stall[5];
  assign load   = ~stall[4];
  // Write-back side effects only fire when write-back itself advances.
  assign commit = ~stall[5];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_we                 <= 1'b0;
      wb_waddr              <= '0;
      wb_wdata              <= '0;
      wb_whilo              <= 1'b0;
      wb_hi                 <= '0;
      wb_lo                 <= '0;
      wb_cnt                <= '0;
      wb_hilo_tempt         <= '0;
      wb_minuend            <= '0;
      wb_LLbit_we           <= 1'b0;
      wb_LLbit_value        <= 1'b0;
      wb_cp0_reg_we         <= 1'b0;
      wb_cp0_reg_write_addr <= '0;
      wb_cp0_reg_data       <= '0;
    end else if (flush) begin
      wb_we                 <= 1'b0;
      wb_waddr              <= '0;
      wb_wdata              <= '0;
      wb_whilo              <= 1'b0;
      wb_hi                 <= '0;
      wb_lo                 <= '0;
      wb_cnt                <= '0;
      wb_hilo_tempt         <= '0;
      wb_minuend            <= '0;
      wb_LLbit_we           <= 1'b0;
      wb_LLbit_value        <= 1'b0;
      wb_cp0_reg_we         <= 1'b0;
      wb_cp0_reg_write_addr <= '0;
      wb_cp0_reg_data       <= '0;
    end else if (bubble) begin
      // Requests are squashed but the mult/div iteration state keeps flowing.
      wb_we                 <= 1'b0;
      wb_waddr              <= '0;
      wb_wdata              <= '0;
      wb_whilo              <= 1'b0;
      wb_hi                 <= '0;
      wb_lo                 <= '0;
      wb_cnt                <= mem_cnt;
      wb_hilo_tempt         <= mem_hilo_tempt;
      wb_minuend            <= mem_minuend;
      wb_LLbit_we           <= 1'b0;
      wb_LLbit_value        <= 1'b0;
      wb_cp0_reg_we         <= 1'b0;
      wb_cp0_reg_write_addr <= '0;
      wb_cp0_reg_data       <= '0;
    end else if (load) begin
      wb_we                 <= mem_we;
      wb_waddr              <= mem_waddr;
      wb_wdata              <= mem_wdata;
      wb_whilo              <= mem_whilo;
      wb_hi                 <= mem_hi;
      wb_lo                 <= mem_lo;
      wb_cnt                <= mem_cnt;
      wb_hilo_tempt         <= mem_hilo_tempt;
      wb_minuend            <= mem_minuend;
      wb_LLbit_we           <= mem_LLbit_we;
      wb_LLbit_value        <= mem_LLbit_value;
      wb_cp0_reg_we         <= mem_cp0_reg_we;
      wb_cp0_reg_write_addr <= mem_cp0_reg_write_addr;
      wb_cp0_reg_data       <= mem_cp0_reg_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      LLbit_o <= 1'b0;
    end else if (flush) begin
      LLbit_o <= 1'b0;
    end else if (wb_LLbit_we && commit) begin
      LLbit_o <= wb_LLbit_value;
    end
  end

  // A flush discards the pending HI/LO request rather than committing it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (wb_whilo && commit && !flush) begin
      hi_o <= wb_hi;
      lo_o <= wb_lo;
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: directed scenarios plus randomized traffic against a
// stage-level reference model.
module tb_mem_wb;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [5:0]  cnt;
    logic [63:0] tempt;
    logic [63:0] minuend;
    logic        llwe;
    logic        llval;
    logic        cpwe;
    logic [4:0]  cpa;
    logic [31:0] cpd;
  } stage_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  stage_t      in = '0;
  stage_t      obs;

  logic        wb_we, wb_whilo, wb_LLbit_we, wb_LLbit_value, wb_cp0_reg_we, LLbit_o;
  logic [4:0]  wb_waddr, wb_cp0_reg_write_addr;
  logic [31:0] wb_wdata, wb_hi, wb_lo, wb_cp0_reg_data, hi_o, lo_o;
  logic [5:0]  wb_cnt;
  logic [63:0] wb_hilo_tempt, wb_minuend;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .mem_we(in.we), .mem_waddr(in.waddr), .mem_wdata(in.wdata),
    .mem_whilo(in.whilo), .mem_hi(in.hi), .mem_lo(in.lo),
    .mem_cnt(in.cnt), .mem_hilo_tempt(in.tempt), .mem_minuend(in.minuend),
    .mem_LLbit_we(in.llwe), .mem_LLbit_value(in.llval),
    .mem_cp0_reg_we(in.cpwe), .mem_cp0_reg_write_addr(in.cpa), .mem_cp0_reg_data(in.cpd),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_cnt(wb_cnt), .wb_hilo_tempt(wb_hilo_tempt), .wb_minuend(wb_minuend),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .wb_cp0_reg_we(wb_cp0_reg_we), .wb_cp0_reg_write_addr(wb_cp0_reg_write_addr),
    .wb_cp0_reg_data(wb_cp0_reg_data),
    .LLbit_o(LLbit_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  assign obs = {wb_we, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_cnt,
                wb_hilo_tempt, wb_minuend, wb_LLbit_we, wb_LLbit_value,
                wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data};

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stage_t rand_stage();
    stage_t s;
    s.we = 1'($urandom); s.waddr = 5'($urandom); s.wdata = $urandom;
    s.whilo = 1'($urandom); s.hi = $urandom; s.lo = $urandom;
    s.cnt = 6'($urandom); s.tempt = {$urandom, $urandom}; s.minuend = {$urandom, $urandom};
    s.llwe = 1'($urandom); s.llval = 1'($urandom);
    s.cpwe = 1'($urandom); s.cpa = 5'($urandom); s.cpd = $urandom;
    return s;
  endfunction

  task automatic test_reset();
    in = '0; in.we = 1'b1; in.waddr = 5'd9; in.wdata = 32'h1111_2222;
    in.whilo = 1'b1; in.hi = 32'hAAAA_0001; in.lo = 32'hBBBB_0002;
    in.llwe = 1'b1; in.llval = 1'b1; in.cnt = 6'd3;
    stall = '0; flush = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (LLbit_o !== 1'b1 || hi_o !== 32'hAAAA_0001) begin
      failures++; $display("FAIL reset_pre ll=%0b hi=%h required ll=1 hi=aaaa0001", LLbit_o, hi_o);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0 || LLbit_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
      failures++; $display("FAIL reset_async wb=%h ll=%0b hi=%h lo=%h required all zero", obs, LLbit_o, hi_o, lo_o);
    end
    in = '0; in.we = 1'b1; in.waddr = 5'd5; in.wdata = 32'hDEAD_BEEF;
    #1 reset_n = 1'b1;
    tick();
    checks++;
    if (wb_we !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL reset_first_load we=%0b waddr=%0d wdata=%h required 1 5 deadbeef", wb_we, wb_waddr, wb_wdata);
    end
  endtask

  task automatic test_ll_sc();
    in = '0; in.llwe = 1'b1; in.llval = 1'b1;
    tick();
    checks++;
    if (wb_LLbit_we !== 1'b1 || wb_LLbit_value !== 1'b1 || LLbit_o !== 1'b0) begin
      failures++; $display("FAIL ll_edge1 wb_we=%0b wb_val=%0b ll=%0b required 1 1 0", wb_LLbit_we, wb_LLbit_value, LLbit_o);
    end
    in = '0;
    tick();
    checks++;
    if (LLbit_o !== 1'b1) begin
      failures++; $display("FAIL ll_edge2 ll=%0b required 1", LLbit_o);
    end
    in.llwe = 1'b1; in.llval = 1'b0;
    tick();
    in = '0;
    checks++;
    if (LLbit_o !== 1'b1) begin
      failures++; $display("FAIL sc_edge1 ll=%0b required 1", LLbit_o);
    end
    tick();
    checks++;
    if (LLbit_o !== 1'b0) begin
      failures++; $display("FAIL sc_edge2 ll=%0b required 0", LLbit_o);
    end
  endtask

  task automatic test_hilo();
    logic [31:0] old_hi, old_lo;
    old_hi = hi_o; old_lo = lo_o;
    in = '0; in.whilo = 1'b1; in.hi = 32'h1234_5678; in.lo = 32'h9ABC_DEF0;
    tick();
    checks++;
    if (wb_whilo !== 1'b1 || wb_hi !== 32'h1234_5678 || wb_lo !== 32'h9ABC_DEF0 ||
        hi_o !== old_hi || lo_o !== old_lo) begin
      failures++; $display("FAIL hilo_edge1 wb=%0b %h %h arch=%h %h required 1 12345678 9abcdef0 %h %h",
                           wb_whilo, wb_hi, wb_lo, hi_o, lo_o, old_hi, old_lo);
    end
    in = '0; in.hi = 32'h5555_5555; in.lo = 32'h6666_6666;
    tick(); tick(); tick();
    checks++;
    if (hi_o !== 32'h1234_5678 || lo_o !== 32'h9ABC_DEF0) begin
      failures++; $display("FAIL hilo_commit hi=%h lo=%h required 12345678 9abcdef0", hi_o, lo_o);
    end
  endtask

  task automatic test_flush();
    logic [31:0] old_hi, old_lo;
    old_hi = hi_o; old_lo = lo_o;
    in = '0; in.llwe = 1'b1; in.llval = 1'b1;
    tick(); tick();
    in.we = 1'b1; in.waddr = 5'd7; in.wdata = 32'hCAFE_F00D; in.cnt = 6'd9;
    in.cpwe = 1'b1; in.cpa = 5'd3; in.cpd = 32'h77;
    tick();
    checks++;
    if (LLbit_o !== 1'b1 || wb_LLbit_we !== 1'b1 || wb_LLbit_value !== 1'b1) begin
      failures++; $display("FAIL flush_setup ll=%0b wb_we=%0b wb_val=%0b required 1 1 1", LLbit_o, wb_LLbit_we, wb_LLbit_value);
    end
    flush = 1'b1; stall = 6'b110000;
    tick();
    flush = 1'b0; stall = '0; in = '0;
    checks++;
    if (LLbit_o !== 1'b0 || obs !== '0 || hi_o !== old_hi || lo_o !== old_lo) begin
      failures++; $display("FAIL flush_prio ll=%0b wb=%h hi=%h lo=%h required 0 zero %h %h",
                           LLbit_o, obs, hi_o, lo_o, old_hi, old_lo);
    end
  endtask

  task automatic test_bubble_hold();
    stage_t held;
    logic [31:0] old_hi;
    in = '0; in.we = 1'b1; in.waddr = 5'd3; in.wdata = 32'h0BAD_0BAD; in.cnt = 6'd7;
    stall = 6'b010000;
    tick();
    checks++;
    if (wb_we !== 1'b0 || wb_wdata !== '0 || wb_waddr !== '0 || wb_cnt !== 6'd7) begin
      failures++; $display("FAIL bubble we=%0b wdata=%h waddr=%0d cnt=%0d required 0 0 0 7", wb_we, wb_wdata, wb_waddr, wb_cnt);
    end
    stall = '0; old_hi = hi_o;
    in = rand_stage(); in.whilo = 1'b1; in.hi = old_hi ^ 32'hFFFF_0000; in.llwe = 1'b0;
    held = in;
    tick();
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      in = rand_stage();
      tick();
      checks++;
      if (obs !== held || hi_o !== old_hi) begin
        failures++; $display("FAIL hold_%0d wb=%h hi=%h required %h %h", i, obs, hi_o, held, old_hi);
      end
    end
    stall = '0; in = '0;
    tick();
    checks++;
    if (hi_o !== (old_hi ^ 32'hFFFF_0000)) begin
      failures++; $display("FAIL hold_release_commit hi=%h required %h", hi_o, old_hi ^ 32'hFFFF_0000);
    end
  endtask

  task automatic test_cp0();
    in = '0; in.cpwe = 1'b1; in.cpa = 5'd12; in.cpd = 32'h0000_FF01;
    tick();
    checks++;
    if (wb_cp0_reg_we !== 1'b1 || wb_cp0_reg_write_addr !== 5'd12 || wb_cp0_reg_data !== 32'h0000_FF01) begin
      failures++; $display("FAIL cp0_pass we=%0b addr=%0d data=%h required 1 12 0000ff01",
                           wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data);
    end
    stall = 6'b010000;
    tick();
    stall = '0; in = '0;
    checks++;
    if (wb_cp0_reg_we !== 1'b0 || wb_cp0_reg_write_addr !== '0 || wb_cp0_reg_data !== '0) begin
      failures++; $display("FAIL cp0_bubble we=%0b addr=%0d data=%h required 0 0 0",
                           wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data);
    end
  endtask

  // Reference: the stage is a box that copies, squashes, keeps or clears its
  // contents; commits use whatever request sat in the box before the edge.
  task automatic test_random();
    stage_t exp, nxt;
    logic exp_ll;
    logic [31:0] exp_hi, exp_lo;
    int errs;
    errs = 0;
    in = '0; stall = '0; flush = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1 reset_n = 1'b1;
    exp = '0; exp_ll = 1'b0; exp_hi = '0; exp_lo = '0;
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      stall = (sel < 6) ? 6'b000000 : (sel < 8) ? 6'b010000 : 6'b110000;
      flush = ($urandom_range(0, 15) == 0);
      in = rand_stage();
      if (flush) exp_ll = 1'b0;
      else if (exp.llwe && !stall[5]) exp_ll = exp.llval;
      if (exp.whilo && !stall[5] && !flush) begin exp_hi = exp.hi; exp_lo = exp.lo; end
      if (flush) nxt = '0;
      else if (stall == 6'b010000) begin
        nxt = '0; nxt.cnt = in.cnt; nxt.tempt = in.tempt; nxt.minuend = in.minuend;
      end else if (stall == 6'b000000) nxt = in;
      else nxt = exp;
      exp = nxt;
      tick();
      checks++;
      if (obs !== exp || LLbit_o !== exp_ll || hi_o !== exp_hi || lo_o !== exp_lo) begin
        failures++; errs++;
        if (errs <= 5)
          $display("FAIL random_%0d wb=%h ll=%0b hi=%h lo=%h required %h %0b %h %h",
                   n, obs, LLbit_o, hi_o, lo_o, exp, exp_ll, exp_hi, exp_lo);
      end
    end
    flush = 1'b0; stall = '0;
  endtask

  initial begin
    test_reset();
    test_ll_sc();
    test_hilo();
    test_flush();
    test_bubble_hold();
    test_cp0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
